// File: rtl/wm_scan_if.sv
// Handshake bundle between the scan controller, its shift selector and the candidate verifier.
interface wm_scan_if #(
    parameter int SHIFT_W = 8,
    parameter int ADDR_W  = 16
);
    logic               start;
    logic [ADDR_W-1:0]  text_len;
    logic               win_req;
    logic [ADDR_W-1:0]  win_addr;
    logic               shift_valid;
    logic [SHIFT_W-1:0] shift_in;
    logic               match_req;
    logic [ADDR_W-1:0]  match_addr;
    logic               match_ack;
    logic [ADDR_W-1:0]  match_count;
    logic               busy;
    logic               done;

    modport master (
        input  start, text_len, shift_valid, shift_in, match_ack,
        output win_req, win_addr, match_req, match_addr, match_count, busy, done
    );

    modport slave (
        output start, text_len, shift_valid, shift_in, match_ack,
        input  win_req, win_addr, match_req, match_addr, match_count, busy, done
    );
endinterface

// File: rtl/wm_scan_controller.sv
// Wu-Manber style window scanner: walks the text by looked-up minimum shifts and
// hands zero-shift windows to an external verifier.
//
// state      | meaning
// IDLE       | waiting for start
// REQ        | issue a shift lookup for the window ending at pos
// WAIT_SHIFT | waiting for the selector's shift value
// VERIFY     | candidate match outstanding until the verifier acknowledges
// DONE       | one-cycle completion pulse, then back to IDLE
module wm_scan_controller #(
    parameter int SHIFT_W = 8,
    parameter int ADDR_W  = 16,
    parameter int MIN_LEN = 8
) (
    input  logic      clk,
    input  logic      rst,
    wm_scan_if.master bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REQ        = 3'd1;
    localparam logic [2:0] S_WAIT_SHIFT = 3'd2;
    localparam logic [2:0] S_VERIFY     = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    // Wide enough that pos+shift never wraps, so an overshoot always ends the scan.
    localparam int SUM_W = ((SHIFT_W > ADDR_W) ? SHIFT_W : ADDR_W) + 1;

    localparam logic [ADDR_W-1:0] FIRST_POS = ADDR_W'(MIN_LEN - 1);
    localparam logic [ADDR_W-1:0] COUNT_MAX = '1;

    logic [2:0]        state, state_nx;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] len;
    logic [SUM_W-1:0]  shift_sum;
    logic [SUM_W-1:0]  step_sum;
    logic [SUM_W-1:0]  len_w;

    assign shift_sum = SUM_W'(pos) + SUM_W'(bus.shift_in);
    assign step_sum  = SUM_W'(pos) + SUM_W'(1);
    assign len_w     = SUM_W'(len);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nx = (bus.text_len <= FIRST_POS) ? S_DONE : S_REQ;
            end
            S_REQ: state_nx = S_WAIT_SHIFT;
            S_WAIT_SHIFT: begin
                if (bus.shift_valid) begin
                    if (bus.shift_in == '0)
                        state_nx = S_VERIFY;
                    else
                        state_nx = (shift_sum < len_w) ? S_REQ : S_DONE;
                end
            end
            S_VERIFY: begin
                if (bus.match_ack)
                    state_nx = (step_sum < len_w) ? S_REQ : S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pos             <= '0;
            len             <= '0;
            bus.win_req     <= 1'b0;
            bus.win_addr    <= '0;
            bus.match_req   <= 1'b0;
            bus.match_addr  <= '0;
            bus.match_count <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state       <= state_nx;
            bus.busy    <= (state_nx != S_IDLE);
            bus.win_req <= (state == S_REQ);
            bus.done    <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len             <= bus.text_len;
                        pos             <= FIRST_POS;
                        bus.match_count <= '0;
                    end
                end
                S_REQ: bus.win_addr <= pos;
                S_WAIT_SHIFT: begin
                    if (bus.shift_valid) begin
                        if (bus.shift_in == '0) begin
                            bus.match_req  <= 1'b1;
                            bus.match_addr <= pos - FIRST_POS;
                            if (bus.match_count != COUNT_MAX)
                                bus.match_count <= bus.match_count + 1'b1;
                        end else begin
                            pos <= shift_sum[ADDR_W-1:0];
                        end
                    end
                end
                S_VERIFY: begin
                    if (bus.match_ack) begin
                        bus.match_req <= 1'b0;
                        pos           <= step_sum[ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
